// File: rtl/im_loader.sv
// rtl/im_loader.sv - framed byte-stream loader that writes instruction memory and gates CPU reset
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   start      one-cycle pulse; begins a load from IDLE, DONE or ERROR
//   in_valid   byte source has in_data available
//   in_data    stream byte (frame: LEN_HI, LEN_LO, N*4 payload bytes MSB first, XOR checksum)
//   in_ready   loader accepts in_data this cycle
//   im_we      IM write strobe, one cycle per word
//   im_addr    IM word address
//   im_wdata   IM write data
//   cpu_rst    active-low CPU reset; high only once a verified image is in IM
//   busy       load in progress
//   done       image loaded and checksum matched (held until next start)
//   err        bad length or checksum mismatch (held until next start)

module im_loader #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 im_we,
  output logic [ADDR_BITS-1:0] im_addr,
  output logic [31:0]          im_wdata,
  output logic                 cpu_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Counter needs one extra bit so a full 2^ADDR_BITS-word image can be counted.
  localparam int          CW        = ADDR_BITS + 1;
  localparam logic [15:0] MAX_WORDS = 16'(1 << ADDR_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_WORD,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                 state;
  state_t                 state_next;

  logic [7:0]             len_hi;
  logic [15:0]            len;
  logic [CW-1:0]          counter;
  logic [1:0]             byte_idx;
  logic [7:0]             csum;
  logic [31:0]            word;
  logic [ADDR_BITS-1:0]   addr_q;

  logic                   xfer;
  logic [15:0]            len_word;
  logic                   last_word;

  assign xfer      = in_valid && in_ready;
  assign len_word  = {len_hi, in_data};
  assign last_word = (16'(counter) + 16'd1) == len;

  // All handshake and status outputs decode from state only, so in_ready has
  // no combinational dependence on in_valid.
  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_WORD)   || (state == S_CHECK);
  assign im_we    = (state == S_WRITE);
  assign busy     = in_ready || (state == S_WRITE);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERROR);
  assign cpu_rst  = (state == S_DONE);
  assign im_addr  = addr_q;
  assign im_wdata = word;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (xfer) begin
          if (len_word > MAX_WORDS)  state_next = S_ERROR;
          else if (len_word == 16'd0) state_next = S_CHECK;
          else                        state_next = S_WORD;
        end
      end
      S_WORD: begin
        if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = last_word ? S_CHECK : S_WORD;
      end
      S_CHECK: begin
        if (xfer) state_next = (in_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_hi   <= '0;
      len      <= '0;
      counter  <= '0;
      byte_idx <= '0;
      csum     <= '0;
      word     <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            counter  <= '0;
            byte_idx <= '0;
            csum     <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) len_hi <= in_data;
        end
        S_LEN_LO: begin
          if (xfer) len <= len_word;
        end
        S_WORD: begin
          if (xfer) begin
            word     <= {word[23:0], in_data};
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            // Address is latched with the last byte so it is stable during WRITE;
            // counter is at most N-1 here, which always fits ADDR_BITS.
            if (byte_idx == 2'd3) addr_q <= counter[ADDR_BITS-1:0];
          end
        end
        S_WRITE: begin
          counter  <= counter + CW'(1);
          byte_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Byte-stream program loader: the writer side of instruction memory, which the single-cycle CPU only reads.
- Accepts a framed byte stream and assembles big-endian 32-bit instruction words.
- Writes each word into IM through a dedicated write port and holds the CPU in reset until the image is verified.
- Sits between the board-level byte source (UART RX / debug bridge) and the IM write port / CPU rst input.

Parameters:
- ADDR_BITS, 10, IM address width; capacity is 2^ADDR_BITS words (1024).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR
- in_valid  input  1  byte source has in_data available
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts in_data this cycle; a byte transfers when in_valid && in_ready
- im_we  output  1  IM write strobe, one cycle per word
- im_addr  output  ADDR_BITS  IM word address
- im_wdata  output  32  IM write data
- cpu_rst  output  1  drives the CPU's active-low rst; 0 = CPU held in reset
- busy  output  1  load in progress (any state except IDLE/DONE/ERROR)
- done  output  1  sticky; image loaded and checksum matched
- err  output  1  sticky; bad length or checksum mismatch

Behaviour:
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 payload bytes, each word MSB first.
  - One checksum byte equal to the XOR of all payload bytes. Length bytes are excluded from the checksum.
- Reset (rst=1 at a clk edge, any state, including mid-load):
  - state=IDLE.
  - in_ready, im_we, busy, done, err = 0; cpu_rst = 0.
  - im_addr, im_wdata, word counter, byte index and checksum accumulator = 0.
  - Partially written IM contents are left as is.
- States: IDLE, LEN_HI, LEN_LO, WORD, WRITE, CHECK, DONE, ERROR.
- IDLE:
  - in_ready=0; cpu_rst=0.
  - start → LEN_HI. On this transition clear done, err, counter, byte index and checksum.
- LEN_HI / LEN_LO:
  - in_ready=1; each accepted byte is stored.
  - After LEN_LO: N > 2^ADDR_BITS → ERROR; N = 0 → CHECK; otherwise → WORD.
- WORD:
  - in_ready=1.
  - Each accepted byte shifts into the word register (wdata = {wdata[23:0], byte}) and is XORed into the checksum.
  - Accepting the 4th byte (index 3) → WRITE.
- WRITE (exactly one cycle):
  - in_ready=0; im_we=1; im_addr=counter; im_wdata=assembled word.
  - Next edge: counter+1, byte index=0.
  - → CHECK if counter == N-1, else → WORD.
  - Write latency: strobe occurs the cycle after the 4th byte is accepted.
- CHECK:
  - in_ready=1.
  - Accepted byte == checksum → DONE; otherwise → ERROR.
- DONE:
  - done=1; cpu_rst=1, releasing the CPU; in_ready=0.
  - start → LEN_HI, which clears done and drops cpu_rst to 0 on the same edge.
- ERROR:
  - err=1; cpu_rst=0; in_ready=0.
  - start → LEN_HI.
- start while busy is ignored.
- Backpressure: in_valid may drop at any time. No state advances and nothing is accumulated without a transfer. in_data is ignored when in_valid=0.
- im_we is asserted only in WRITE. im_addr never exceeds 2^ADDR_BITS-1. The counter never wraps, because N is range-checked first.
- busy=1 exactly in LEN_HI, LEN_LO, WORD, WRITE and CHECK.
- No timeout: the loader waits indefinitely for bytes.
- All outputs are registered or decoded from state only; there is no combinational path from in_valid to in_ready.

Test Plan:
- Nominal load, continuous valid:
  - Stimulus: start, then bytes 00 02 20 01 00 05 FC 00 00 00 D8.
  - Required: im_we pulses twice, (addr 0, 0x20010005) then (addr 1, 0xFC000000).
  - Required: done=1, cpu_rst=1, err=0, busy=0.
- Checksum mismatch:
  - Stimulus: same stream with final byte D9.
  - Required: both writes still occur; err=1, done=0, cpu_rst stays 0.
- Empty image:
  - Stimulus: 00 00 00.
  - Required: no im_we; done=1, cpu_rst=1.
  - Stimulus: 00 00 01.
  - Required: err=1.
- Oversize length:
  - Stimulus: 04 01 (N=1025, ADDR_BITS=10).
  - Required: ERROR right after LEN_LO; no im_we; in_ready=0 thereafter.
  - Stimulus: start with 04 00 plus 4096 payload bytes.
  - Required: last write at addr 0x3FF.
- Backpressure and ignored start:
  - Stimulus: nominal stream with in_valid deasserted 1–3 cycles between bytes, and a start pulse mid-payload.
  - Required: identical writes and done; only valid&&ready transfers counted.
- Reset mid-load and reload:
  - Stimulus: rst=1 after 5 payload bytes, then a full nominal load.
  - Required: IDLE, outputs at reset values; the second load produces correct writes and done=1.
  - Required: start from DONE drops cpu_rst to 0 on that edge.
